// File: rtl/fetch_stage.sv
// Instruction fetch: owns PCF, issues imem requests, fills the IF/ID register for decode.
// Latency: zero-wait fetch reaches InstrD next cycle; StallF/StallD hold state; redirects win over stalls.
module fetch_stage #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic             BranchTakenE,
   input  logic [WIDTH-1:0] ALUResultE,
   input  logic             PCSrcW,
   input  logic [WIDTH-1:0] ResultW,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0] imem_rdata,
   input  logic             imem_ready,
   output logic [WIDTH-1:0] PCF,
   output logic [WIDTH-1:0] InstrD,
   output logic [WIDTH-1:0] PCPlus8D,
   output logic             ValidD
);

   typedef enum logic [1:0] {S_FETCH, S_READY, S_DRAIN} state_t;

   localparam logic [WIDTH-1:0] PC_INC  = WIDTH'(4);
   localparam logic [WIDTH-1:0] PC_INC8 = WIDTH'(8);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] fbuf_q, fbuf_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] instr_q, pc8_q;
   logic             valid_q;

   logic             stall_f;
   logic             redirect;
   logic [WIDTH-1:0] target;
   logic             ld_vld;
   logic [WIDTH-1:0] ld_instr;

   // A stalled decode with a running fetch is illegal; fold it into StallF.
   assign stall_f  = StallF | StallD;
   assign redirect = BranchTakenE | PCSrcW;
   assign target   = BranchTakenE ? ALUResultE : ResultW;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      fbuf_d   = fbuf_q;
      pend_d   = pend_q;
      ld_vld   = 1'b0;
      ld_instr = '0;
      case (state_q)
         S_FETCH: begin
            if (redirect) begin
               if (imem_ready) begin
                  pc_d = target;
               end else begin
                  pend_d  = target;
                  state_d = S_DRAIN;
               end
            end else if (imem_ready) begin
               if (!stall_f) begin
                  pc_d     = pc_q + PC_INC;
                  ld_vld   = 1'b1;
                  ld_instr = imem_rdata;
               end else begin
                  fbuf_d  = imem_rdata;
                  state_d = S_READY;
               end
            end
         end
         S_READY: begin
            if (redirect) begin
               pc_d    = target;
               state_d = S_FETCH;
            end else if (!stall_f) begin
               pc_d     = pc_q + PC_INC;
               ld_vld   = 1'b1;
               ld_instr = fbuf_q;
               state_d  = S_FETCH;
            end
         end
         S_DRAIN: begin
            // The outstanding response belongs to the old path and is dropped.
            if (imem_ready) begin
               pc_d    = redirect ? target : pend_q;
               state_d = S_FETCH;
            end else if (redirect) begin
               pend_d = target;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         fbuf_q  <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fbuf_q  <= fbuf_d;
         pend_q  <= pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || FlushD) begin
         instr_q <= '0;
         pc8_q   <= '0;
         valid_q <= 1'b0;
      end else if (!StallD) begin
         instr_q <= ld_vld ? ld_instr : '0;
         pc8_q   <= ld_vld ? (pc_q + PC_INC8) : '0;
         valid_q <= ld_vld;
      end
   end

   assign imem_req  = !rst && (state_q != S_READY);
   assign imem_addr = pc_q;
   assign PCF       = pc_q;
   assign InstrD    = instr_q;
   assign PCPlus8D  = pc8_q;
   assign ValidD    = valid_q;

endmodule
